add_seq_ctrl: RTL and testbench

Sequencing stage wrapped around the 8-bit ripple-carry adder. It accepts operand transactions over a valid/ready handshake and drives registered operands into the combinational adder. After a programmable settle interval it captures the adder's sum and carry. It presents the captured result downstream over a second valid/ready handshake, and maintains an accumulator and an overflow counter.

---
 rtl/add_seq_if.sv | 41 ++++
 rtl/add_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_add_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_if.sv
// Handshake and adder-side bus for the add_seq_ctrl sequencing stage.
// slave = the controller, master = whoever drives operands/consumes results
// and hosts the combinational adder.
interface add_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_acc;
    logic             acc_clr;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic [WIDTH-1:0] acc_q;
    logic [7:0]       ovf_cnt;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_acc, acc_clr,
        input  add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin,
        output out_valid, out_sum, out_cout, acc_q, ovf_cnt
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_acc, acc_clr,
        output add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin,
        input  out_valid, out_sum, out_cout, acc_q, ovf_cnt
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// Sequencing stage around an external ripple-carry adder: registers the
// operands, waits SETTLE cycles for the ripple to settle, captures the sum,
// and offers it downstream. Keeps an accumulator and a saturating count of
// carry-out captures.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  S_IDLE  | ready for an operand transaction
//  S_DRIVE | operands held on the adder, settle timer counting down
//  S_HOLD  | captured result offered downstream until out_ready
//
// SETTLE legal range is 1..15 (4-bit settle timer).
module add_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    add_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_add_cin;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;
    logic [WIDTH-1:0] r_acc;
    logic [7:0]       r_ovf;
    logic             w_accept;
    logic             w_capture;
    logic             w_in_ready;
    logic             w_out_valid;

    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
    assign w_capture = (r_state == S_DRIVE) && (r_cnt == 4'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; both handshakes depend on state only
    // (in_ready is additionally held low while reset is asserted).
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = rst_n;
                if (bus.in_valid) begin
                    w_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Settle timer: loaded on accept, counts down while driving the adder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 4'(SETTLE);
        end else if (r_state == S_DRIVE) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Operand registers feeding the adder; only change on the accept edge.
    // In accumulate mode the pre-clear accumulator value is used.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_cin <= 1'b0;
        end else if (w_accept) begin
            r_add_a   <= bus.in_acc ? r_acc : bus.in_a;
            r_add_b   <= bus.in_b;
            r_add_cin <= bus.in_cin;
        end
    end

    // Result capture; held stable until the next capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
        end else if (w_capture) begin
            r_out_sum  <= bus.add_sum;
            r_out_cout <= bus.add_cout;
        end
    end

    // Accumulator and saturating overflow counter; clear beats capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 8'd0;
        end else if (bus.acc_clr) begin
            r_acc <= '0;
            r_ovf <= 8'd0;
        end else if (w_capture) begin
            r_acc <= bus.add_sum;
            if (bus.add_cout && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 8'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.add_cin   = r_add_cin;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_cout  = r_out_cout;
    assign bus.acc_q     = r_acc;
    assign bus.ovf_cnt   = r_ovf;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: hosts the combinational adder, runs a table of
// directed vectors, hand sequences for reset/saturation/clear, and random
// transactions checked against a transaction-level reference model.
module tb_add_seq_ctrl;
    localparam int WIDTH  = 8;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst_n;

    add_seq_if #(.WIDTH(WIDTH)) bus ();

    add_seq_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The external ripple-carry adder, modelled behaviourally.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: accumulator and saturating overflow count.
    logic [7:0] m_acc = 8'd0;
    logic [7:0] m_ovf = 8'd0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       acc;
        logic [7:0] exp_adda;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic [7:0] exp_ovf;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: result of one add and its effect on acc/ovf.
    task automatic model_txn(input logic [7:0] a, input logic [7:0] b, input logic cin,
                             input logic acc, input logic clr,
                             output logic [7:0] exp_sum, output logic exp_cout);
        int s;
        s = int'(acc ? m_acc : a) + int'(b) + int'(cin);
        exp_sum  = 8'(s % 256);
        exp_cout = (s >= 256);
        if (clr) begin
            m_acc = 8'd0;
            m_ovf = 8'd0;
        end else begin
            m_acc = exp_sum;
            if (exp_cout && m_ovf < 8'd255) m_ovf = m_ovf + 8'd1;
        end
    endtask

    // One transaction: accept, measure latency, optional backpressure, consume.
    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic acc, input logic clr, input int hold,
                          output logic [7:0] got_sum, output logic got_cout,
                          output logic [7:0] got_adda);
        logic [7:0] exp_adda;
        logic [7:0] s0;
        logic [7:0] a0;
        int n;
        exp_adda = acc ? m_acc : a;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_acc    = acc;
        bus.out_ready = 1'b0;
        step();
        got_adda = bus.add_a;
        check("add_a_loaded", 32'(bus.add_a), 32'(exp_adda));
        check("in_ready_drive", 32'(bus.in_ready), 32'd0);
        bus.in_a = ~a;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            if (clr && n == SETTLE - 1) bus.acc_clr = 1'b1;
            bus.in_valid = n[0];
            step();
            bus.acc_clr = 1'b0;
            n++;
        end
        bus.in_valid = 1'b0;
        check("latency", 32'(n), 32'(SETTLE));
        got_sum  = bus.out_sum;
        got_cout = bus.out_cout;
        s0 = bus.out_sum;
        a0 = bus.add_a;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            step();
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_sum", 32'(bus.out_sum), 32'(s0));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_add_a", 32'(bus.add_a), 32'(a0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("consumed_out_valid", 32'(bus.out_valid), 32'd0);
        check("consumed_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] gs;
        logic       gc;
        logic [7:0] ga;
        logic [7:0] es;
        logic       ec;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rcin;
        logic       racc;
        logic       rclr;
        int         seen_valid;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h0F, 8'h10, 1'b0, 8'd0};
        tbl[1] = '{8'hAA, 8'h05, 1'b0, 1'b1, 8'h10, 8'h15, 1'b0, 8'd0};
        tbl[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b1, 8'd1};
        tbl[3] = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 8'd2};
        tbl[4] = '{8'h3C, 8'hC4, 1'b1, 1'b0, 8'h3C, 8'h01, 1'b1, 8'd3};
        tbl[5] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h7F, 8'h80, 1'b0, 8'd3};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'd0;
        bus.in_b      = 8'd0;
        bus.in_cin    = 1'b0;
        bus.in_acc    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        step();
        step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_add_a", 32'(bus.add_a), 32'd0);
        check("rst_add_b", 32'(bus.add_b), 32'd0);
        check("rst_add_cin", 32'(bus.add_cin), 32'd0);
        check("rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("rst_out_cout", 32'(bus.out_cout), 32'd0);
        check("rst_acc_q", 32'(bus.acc_q), 32'd0);
        check("rst_ovf_cnt", 32'(bus.ovf_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed table; vector 2 also exercises 5 cycles of backpressure.
        for (int i = 0; i < 6; i++) begin
            do_txn(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].acc, 1'b0, (i == 2) ? 5 : 0, gs, gc, ga);
            model_txn(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].acc, 1'b0, es, ec);
            check("tbl_add_a", 32'(ga), 32'(tbl[i].exp_adda));
            check("tbl_out_sum", 32'(gs), 32'(tbl[i].exp_sum));
            check("tbl_out_cout", 32'(gc), 32'(tbl[i].exp_cout));
            check("tbl_acc_q", 32'(bus.acc_q), 32'(tbl[i].exp_sum));
            check("tbl_ovf_cnt", 32'(bus.ovf_cnt), 32'(tbl[i].exp_ovf));
        end

        // Reset one edge into DRIVE drops the transaction.
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h11;
        bus.in_b     = 8'h22;
        bus.in_cin   = 1'b0;
        bus.in_acc   = 1'b0;
        step();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_add_a", 32'(bus.add_a), 32'd0);
        check("mid_rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("mid_rst_acc_q", 32'(bus.acc_q), 32'd0);
        check("mid_rst_ovf_cnt", 32'(bus.ovf_cnt), 32'd0);
        rst_n = 1'b1;
        m_acc = 8'd0;
        m_ovf = 8'd0;
        #1;
        check("mid_rst_in_ready_after", 32'(bus.in_ready), 32'd1);
        seen_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.out_valid) seen_valid++;
        end
        check("mid_rst_no_out_valid", 32'(seen_valid), 32'd0);
        do_txn(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 0, gs, gc, ga);
        model_txn(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, es, ec);
        check("after_rst_sum", 32'(gs), 32'h07);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 150; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rcin = 1'($urandom_range(0, 1));
            racc = 1'($urandom_range(0, 1));
            rclr = ($urandom_range(0, 9) == 0);
            do_txn(ra, rb, rcin, racc, rclr, $urandom_range(0, 3), gs, gc, ga);
            model_txn(ra, rb, rcin, racc, rclr, es, ec);
            check("rnd_out_sum", 32'(gs), 32'(es));
            check("rnd_out_cout", 32'(gc), 32'(ec));
            check("rnd_acc_q", 32'(bus.acc_q), 32'(m_acc));
            check("rnd_ovf_cnt", 32'(bus.ovf_cnt), 32'(m_ovf));
        end

        // acc_clr while idle.
        bus.acc_clr = 1'b1;
        step();
        bus.acc_clr = 1'b0;
        m_acc = 8'd0;
        m_ovf = 8'd0;
        check("idle_clr_acc_q", 32'(bus.acc_q), 32'd0);
        check("idle_clr_ovf_cnt", 32'(bus.ovf_cnt), 32'd0);

        // Saturation of the overflow counter.
        for (int i = 0; i < 260; i++) begin
            do_txn(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 0, gs, gc, ga);
            model_txn(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, es, ec);
        end
        check("sat_ovf_cnt", 32'(bus.ovf_cnt), 32'd255);
        check("sat_out_cout", 32'(bus.out_cout), 32'd1);

        // Clear on a capture edge: clear wins for acc/ovf, result still captured.
        do_txn(8'h90, 8'h80, 1'b0, 1'b0, 1'b1, 0, gs, gc, ga);
        model_txn(8'h90, 8'h80, 1'b0, 1'b0, 1'b1, es, ec);
        check("clr_cap_out_sum", 32'(gs), 32'h10);
        check("clr_cap_out_cout", 32'(gc), 32'd1);
        check("clr_cap_acc_q", 32'(bus.acc_q), 32'd0);
        check("clr_cap_ovf_cnt", 32'(bus.ovf_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
